// File: rtl/return_addr_stack.sv
// ---------------------------------------------------------------------------
// return_addr_stack
//
// Subroutine call/return unit for the microsequencer. It sits directly
// upstream of program_sequencer and drives its jump request.
//   - On a CALL it redirects fetch to the call target.
//   - It also pushes the return address (pc_big + 1).
//   - On a RET it redirects fetch to the most recently pushed address.
// Redirects are combinational, so they land in the same cycle. The push or
// pop commits at the next rising edge.
//
// Ports
//   clk          system clock, all state changes on posedge
//   sync_reset   synchronous active-high reset
//   call         decoded CALL in the executing instruction
//   ret          decoded RET in the executing instruction
//   call_addr    CALL target taken from the instruction field
//   pc_big       address of the executing instruction
//   rs_jmp       jump request to the sequencer (combinational)
//   rs_jmp_addr  jump target to the sequencer (combinational)
//   depth        number of entries held, 0..DEPTH (registered)
//   empty        depth == 0
//   full         depth == DEPTH
//   ovf_err      sticky, set by a CALL while full
//   udf_err      sticky, set by a RET while empty
//   conflict_err sticky, set when call and ret arrive together
// ---------------------------------------------------------------------------
module return_addr_stack #(
  parameter int AW    = 10,
  parameter int DEPTH = 4
) (
  input  logic          clk,
  input  logic          sync_reset,
  input  logic          call,
  input  logic          ret,
  input  logic [AW-1:0] call_addr,
  input  logic [AW-1:0] pc_big,
  output logic          rs_jmp,
  output logic [AW-1:0] rs_jmp_addr,
  output logic [3:0]    depth,
  output logic          empty,
  output logic          full,
  output logic          ovf_err,
  output logic          udf_err,
  output logic          conflict_err
);

  localparam int         IW        = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [3:0] DEPTH_MAX = 4'(DEPTH);

  // LIFO storage. It is deliberately not reset: depth alone says which
  // entries are valid.
  logic [AW-1:0] stack_mem [DEPTH];

  logic [3:0]    depth_reg, depth_next;
  logic          ovf_reg, udf_reg, conflict_reg;
  logic          push, pop;
  logic          is_empty, is_full;
  logic [IW-1:0] wr_idx, top_idx;
  logic [AW-1:0] top_entry;

  assign is_empty = (depth_reg == 4'd0);
  assign is_full  = (depth_reg == DEPTH_MAX);

  // Next free slot is stack[depth]; the top of stack is stack[depth-1].
  // top_idx is garbage when empty, but it is only used when not empty.
  assign wr_idx    = IW'(depth_reg);
  assign top_idx   = IW'(depth_reg - 4'd1);
  assign top_entry = stack_mem[top_idx];

  // Redirect and push/pop decode. CALL wins over RET when both are set.
  // Nothing is requested while reset is held.
  always_comb begin
    rs_jmp      = 1'b0;
    rs_jmp_addr = '0;
    push        = 1'b0;
    pop         = 1'b0;
    if (!sync_reset) begin
      if (call) begin
        rs_jmp      = 1'b1;
        rs_jmp_addr = call_addr;
        // When full, the jump is still taken but the return address is lost.
        push        = !is_full;
      end else if (ret && !is_empty) begin
        rs_jmp      = 1'b1;
        rs_jmp_addr = top_entry;
        pop         = 1'b1;
      end
    end
  end

  always_comb begin
    depth_next = depth_reg;
    if (push) begin
      depth_next = depth_reg + 4'd1;
    end else if (pop) begin
      depth_next = depth_reg - 4'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (sync_reset) begin
      depth_reg    <= 4'd0;
      ovf_reg      <= 1'b0;
      udf_reg      <= 1'b0;
      conflict_reg <= 1'b0;
    end else begin
      depth_reg <= depth_next;
      if (call && is_full) begin
        ovf_reg <= 1'b1;
      end
      if (ret && !call && is_empty) begin
        udf_reg <= 1'b1;
      end
      if (call && ret) begin
        conflict_reg <= 1'b1;
      end
    end
  end

  // The return address wraps modulo 2^AW.
  always_ff @(posedge clk) begin
    if (push) begin
      stack_mem[wr_idx] <= pc_big + AW'(1);
    end
  end

  assign depth        = depth_reg;
  assign empty        = is_empty;
  assign full         = is_full;
  assign ovf_err      = ovf_reg;
  assign udf_err      = udf_reg;
  assign conflict_err = conflict_reg;

endmodule
